imm_extend_stage: RTL and testbench

//  Registered, parametrised immediate-extension stage for the ID->EX path.

---
 rtl/imm_ext_pkg.sv | 9 +
 rtl/imm_ext_core.sv | 20 ++
 rtl/imm_extend_stage.sv | 114 +++++++++++
 tb/tb_imm_extend_stage.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/imm_ext_pkg.sv
// imm_ext_pkg: extension modes and stage FSM states shared by the immediate-extension stage.
package imm_ext_pkg;
    localparam logic [1:0] MODE_SEXT  = 2'd0;
    localparam logic [1:0] MODE_ZEXT  = 2'd1;
    localparam logic [1:0] MODE_UPPER = 2'd2;
    localparam logic [1:0] MODE_BROFF = 2'd3;
    typedef logic [1:0] mode_t;
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
endpackage

// File: rtl/imm_ext_core.sv
// imm_ext_core: combinational sign/zero/upper/branch-offset extension of an IN_W immediate to OUT_W bits.
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic [IN_W-1:0]  imm_i,
    input  mode_t            mode_i,
    output logic [OUT_W-1:0] ext_o
);
    logic [OUT_W-1:0] z, s;
    always_comb begin
        z = {{(OUT_W-IN_W){1'b0}}, imm_i};
        s = {{(OUT_W-IN_W){imm_i[IN_W-1]}}, imm_i};
        ext_o = mode_i == MODE_SEXT  ? s :
                mode_i == MODE_ZEXT  ? z :
                mode_i == MODE_UPPER ? z << IN_W : s << 2;
    end
endmodule

// File: rtl/imm_extend_stage.sv
// imm_extend_stage: registered immediate extension with valid/ready, tag passthrough and flush; IMM_EXT_SKID_EN selects the 2-entry skid build.
module imm_extend_stage
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [IN_W-1:0]  in_imm_i,
    input  mode_t            in_mode_i,
    input  logic [TAG_W-1:0] in_tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [OUT_W-1:0] out_data_o,
    output logic [TAG_W-1:0] out_tag_o,
    output logic             out_neg_o
);
    state_t           state_q, state_d;
    logic [OUT_W-1:0] main_data_q, main_data_d, ext;
    logic [TAG_W-1:0] main_tag_q, main_tag_d;
    logic             accept, drain;

    imm_ext_core #(.IN_W(IN_W), .OUT_W(OUT_W)) u_core (
        .imm_i (in_imm_i),
        .mode_i(in_mode_i),
        .ext_o (ext)
    );

    assign out_valid_o = state_q != EMPTY;
    assign out_data_o  = main_data_q;
    assign out_tag_o   = main_tag_q;
    assign out_neg_o   = main_data_q[OUT_W-1];
    assign accept      = in_valid_i && in_ready_o;
    assign drain       = out_valid_o && out_ready_i;

`ifdef IMM_EXT_SKID_EN
    logic [OUT_W-1:0] skid_data_q, skid_data_d;
    logic [TAG_W-1:0] skid_tag_q, skid_tag_d;
    // Derived from the state register only, so out_ready never reaches in_ready.
    assign in_ready_o = state_q != TWO;
    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_tag_d  = main_tag_q;
        skid_data_d = skid_data_q;
        skid_tag_d  = skid_tag_q;
        case (state_q)
            EMPTY: if (accept) begin
                state_d     = ONE;
                main_data_d = ext;
                main_tag_d  = in_tag_i;
            end
            ONE: if (accept && drain) begin
                main_data_d = ext;
                main_tag_d  = in_tag_i;
            end else if (accept) begin
                state_d     = TWO;
                skid_data_d = ext;
                skid_tag_d  = in_tag_i;
            end else if (drain) begin
                state_d = EMPTY;
            end
            TWO: if (drain) begin
                state_d     = ONE;
                main_data_d = skid_data_q;
                main_tag_d  = skid_tag_q;
            end
            default: state_d = EMPTY;
        endcase
        if (flush_i) state_d = EMPTY;
    end
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            skid_data_q <= '0;
            skid_tag_q  <= '0;
        end else begin
            skid_data_q <= skid_data_d;
            skid_tag_q  <= skid_tag_d;
        end
    end
`else
    assign in_ready_o = !out_valid_o || out_ready_i;
    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_tag_d  = main_tag_q;
        if (accept) begin
            state_d     = ONE;
            main_data_d = ext;
            main_tag_d  = in_tag_i;
        end else if (drain) begin
            state_d = EMPTY;
        end
        if (flush_i) state_d = EMPTY;
    end
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= EMPTY;
            main_data_q <= '0;
            main_tag_q  <= '0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_tag_q  <= main_tag_d;
        end
    end
endmodule

// File: tb/tb_imm_extend_stage.sv
// tb_imm_extend_stage: directed and scoreboarded random checks of imm_extend_stage at default widths.
module tb_imm_extend_stage;
    logic        clk = 0, reset = 1, flush = 0, in_valid = 0, out_ready = 0;
    logic [15:0] in_imm = 0;
    logic [1:0]  in_mode = 0;
    logic [4:0]  in_tag = 0;
    logic        in_ready, out_valid, out_neg;
    logic [31:0] out_data;
    logic [4:0]  out_tag;
    int          vectors = 0, miscompares = 0;
    logic [36:0] sb[$];
    logic [36:0] front;

    imm_extend_stage dut (
        .clk_i(clk), .reset_i(reset), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_imm_i(in_imm),
        .in_mode_i(in_mode), .in_tag_i(in_tag), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .out_data_o(out_data), .out_tag_o(out_tag),
        .out_neg_o(out_neg)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h expected %h", name, obs, exp);
        end
    endtask

    task automatic beat(input logic [15:0] imm, input logic [1:0] mode, input logic [4:0] tag);
        in_valid = 1;
        in_imm   = imm;
        in_mode  = mode;
        in_tag   = tag;
    endtask

    function automatic logic [31:0] ref_ext(input logic [15:0] imm, input logic [1:0] m);
        logic [31:0] s;
        s = {{16{imm[15]}}, imm};
        case (m)
            2'd0:    return s;
            2'd1:    return {16'h0, imm};
            2'd2:    return {imm, 16'h0};
            default: return {s[29:0], 2'b00};
        endcase
    endfunction

    initial begin
        cyc(); cyc();
        check("rst_valid", 32'(out_valid), 0);
        check("rst_data", out_data, 0);
        check("rst_tag", 32'(out_tag), 0);
        check("rst_neg", 32'(out_neg), 0);
        reset = 0;
        #1;
        check("rst_ready", 32'(in_ready), 1);

        out_ready = 1;
        beat(16'h8000, 2'd0, 5'd3); cyc();
        check("sext_valid", 32'(out_valid), 1);
        check("sext_data", out_data, 32'hFFFF8000);
        check("sext_neg", 32'(out_neg), 1);
        check("sext_tag", 32'(out_tag), 3);
        beat(16'h8000, 2'd1, 5'd4); cyc();
        check("zext_data", out_data, 32'h00008000);
        check("zext_neg", 32'(out_neg), 0);
        beat(16'h1234, 2'd2, 5'd5); cyc();
        check("upper_data", out_data, 32'h12340000);
        beat(16'hFFFF, 2'd3, 5'd6); cyc();
        check("broff_data", out_data, 32'hFFFFFFFC);
        check("broff_neg", 32'(out_neg), 1);
        beat(16'h4000, 2'd3, 5'd7); cyc();
        check("broff_pos", out_data, 32'h00010000);
        beat(16'h7FFF, 2'd0, 5'd8); cyc();
        check("sext_pos", out_data, 32'h00007FFF);
        in_valid = 0; cyc();
        check("drained", 32'(out_valid), 0);

        for (int i = 0; i < 8; i++) begin
            beat(16'(i), 2'd1, 5'(i)); cyc();
            check("b2b_valid", 32'(out_valid), 1);
            check("b2b_tag", 32'(out_tag), i);
            check("b2b_data", out_data, i);
        end
        in_valid = 0; cyc();
        check("b2b_end", 32'(out_valid), 0);

        out_ready = 0;
        beat(16'h0011, 2'd1, 5'd10); cyc();
`ifdef IMM_EXT_SKID_EN
        check("stall_ready1", 32'(in_ready), 1);
`else
        check("stall_ready1", 32'(in_ready), 0);
`endif
        beat(16'h0022, 2'd1, 5'd11); cyc();
        check("stall_ready2", 32'(in_ready), 0);
        check("stall_tag", 32'(out_tag), 10);
        beat(16'h0033, 2'd1, 5'd12); cyc();
        check("stall_hold_data", out_data, 32'h11);
        check("stall_hold_tag", 32'(out_tag), 10);
        check("stall_ready3", 32'(in_ready), 0);
        out_ready = 1; cyc();
`ifdef IMM_EXT_SKID_EN
        check("unstall_tag11", 32'(out_tag), 11);
        check("unstall_data11", out_data, 32'h22);
        cyc();
`endif
        check("unstall_tag12", 32'(out_tag), 12);
        check("unstall_data12", out_data, 32'h33);
        in_valid = 0; cyc();
        check("unstall_end", 32'(out_valid), 0);

        out_ready = 0;
        beat(16'h0001, 2'd1, 5'd20); cyc();
        beat(16'h0002, 2'd1, 5'd21); cyc();
        flush = 1;
        beat(16'h0003, 2'd1, 5'd22); cyc();
        check("flush_valid", 32'(out_valid), 0);
        beat(16'h0004, 2'd1, 5'd23); cyc();
        check("flush_drop", 32'(out_valid), 0);
        flush = 0;
        out_ready = 1;
        beat(16'h0042, 2'd1, 5'd24); cyc();
        check("post_flush_tag", 32'(out_tag), 24);
        check("post_flush_data", out_data, 32'h42);
        in_valid = 0; cyc();
        check("post_flush_end", 32'(out_valid), 0);

        out_ready = 0;
        beat(16'h8000, 2'd0, 5'd25); cyc();
        check("pre_rst_valid", 32'(out_valid), 1);
        reset = 1;
        beat(16'h0005, 2'd1, 5'd26); cyc();
        check("midrst_valid", 32'(out_valid), 0);
        check("midrst_data", out_data, 0);
        check("midrst_neg", 32'(out_neg), 0);
        reset = 0;
        in_valid = 0; cyc();
        check("midrst_ready", 32'(in_ready), 1);
        check("midrst_novalid", 32'(out_valid), 0);

        for (int c = 0; c < 400; c++) begin
            in_valid  = 1'($urandom_range(1));
            out_ready = ($urandom_range(3) != 0);
            in_imm    = 16'($urandom);
            in_mode   = 2'($urandom_range(3));
            in_tag    = 5'($urandom_range(31));
            #1;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) check("sb_spurious", 32'(out_tag), 32'hFFFFFFFF);
                else begin
                    front = sb.pop_front();
                    check("sb_data", out_data, front[36:5]);
                    check("sb_tag", 32'(out_tag), 32'(front[4:0]));
                    check("sb_neg", 32'(out_neg), 32'(front[36]));
                end
            end
            if (in_valid && in_ready) sb.push_back({ref_ext(in_imm, in_mode), in_tag});
            cyc();
        end
        in_valid  = 0;
        out_ready = 1;
        for (int c = 0; c < 8 && sb.size() > 0; c++) begin
            #1;
            if (out_valid) begin
                front = sb.pop_front();
                check("sb_drain_data", out_data, front[36:5]);
                check("sb_drain_tag", 32'(out_tag), 32'(front[4:0]));
            end
            cyc();
        end
        check("sb_empty", sb.size(), 0);
        check("sb_final_valid", 32'(out_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
